// File: rtl/alu_bit_serial_sequencer_if.sv
// Request, result and one-bit slice signals of the bit-serial ALU sequencer.
// The sequencer uses the master view; the request source, result consumer and slice use the slave view.
interface alu_bit_serial_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [5:0]       in_funct;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [5:0]       slice_ctl;
   logic             slice_ai;
   logic             slice_bi;
   logic             slice_invb;
   logic             slice_cin;
   logic             slice_sum;
   logic             slice_cout;
   logic             slice_set;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_ovf;
   logic             out_err;

   modport master (
      input  in_valid, in_funct, in_a, in_b,
      input  slice_sum, slice_cout, slice_set,
      input  out_ready,
      output in_ready,
      output slice_ctl, slice_ai, slice_bi, slice_invb, slice_cin,
      output out_valid, out_result, out_zero, out_ovf, out_err
   );

   modport slave (
      output in_valid, in_funct, in_a, in_b,
      output slice_sum, slice_cout, slice_set,
      output out_ready,
      input  in_ready,
      input  slice_ctl, slice_ai, slice_bi, slice_invb, slice_cin,
      input  out_valid, out_result, out_zero, out_ovf, out_err
   );
endinterface

// File: rtl/alu_bit_serial_sequencer.sv
// Bit-serial ALU sequencer: feeds an external one-bit slice LSB-first with a registered
// carry, then assembles the result, applies the SLT correction and returns result/flags.
module alu_bit_serial_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   alu_bit_serial_sequencer_if.master    bus
);

   localparam logic [5:0] F_ADD = 6'd32;
   localparam logic [5:0] F_SUB = 6'd34;
   localparam logic [5:0] F_AND = 6'd36;
   localparam logic [5:0] F_OR  = 6'd37;
   localparam logic [5:0] F_SLT = 6'd42;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic is_legal(input logic [5:0] f);
      case (f)
         F_ADD, F_SUB, F_AND, F_OR, F_SLT: is_legal = 1'b1;
         default:                          is_legal = 1'b0;
      endcase
   endfunction

   state_t           state_r;
   logic [5:0]       funct_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] result_r;
   logic [CNT_W-1:0] idx_r;
   logic             carry_r;
   logic             c_msb_in_r;
   logic             c_msb_out_r;
   logic             set_msb_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_result_r;
   logic             out_zero_r;
   logic             out_ovf_r;
   logic             out_err_r;
   logic [5:0]       slice_ctl_r;
   logic             slice_ai_r;
   logic             slice_bi_r;
   logic             slice_invb_r;
   logic             slice_cin_r;

   logic             req_invb_s;
   logic [CNT_W-1:0] next_idx_s;
   logic             ovf_s;
   logic [WIDTH-1:0] done_result_s;
   logic             done_ovf_s;

   assign req_invb_s = (bus.in_funct == F_SUB) || (bus.in_funct == F_SLT);
   assign next_idx_s = idx_r + CNT_W'(1);
   assign ovf_s      = c_msb_in_r ^ c_msb_out_r;

   // Final result and overflow flag from the assembled bits and MSB carries
   always_comb begin
      done_result_s = {WIDTH{1'b0}};
      done_ovf_s    = 1'b0;
      case (funct_r)
         F_ADD, F_SUB: begin
            done_result_s = result_r;
            done_ovf_s    = ovf_s;
         end
         F_AND, F_OR: begin
            done_result_s = result_r;
            done_ovf_s    = 1'b0;
         end
         F_SLT: begin
            // The raw sign of A-B is wrong exactly when the subtraction overflowed.
            done_result_s = {{(WIDTH-1){1'b0}}, set_msb_r ^ ovf_s};
            done_ovf_s    = 1'b0;
         end
         default: begin
            done_result_s = {WIDTH{1'b0}};
            done_ovf_s    = 1'b0;
         end
      endcase
   end

   // Sequencer FSM with registered handshake, slice and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         funct_r      <= 6'd0;
         a_r          <= {WIDTH{1'b0}};
         b_r          <= {WIDTH{1'b0}};
         result_r     <= {WIDTH{1'b0}};
         idx_r        <= {CNT_W{1'b0}};
         carry_r      <= 1'b0;
         c_msb_in_r   <= 1'b0;
         c_msb_out_r  <= 1'b0;
         set_msb_r    <= 1'b0;
         in_ready_r   <= 1'b1;
         out_valid_r  <= 1'b0;
         out_result_r <= {WIDTH{1'b0}};
         out_zero_r   <= 1'b0;
         out_ovf_r    <= 1'b0;
         out_err_r    <= 1'b0;
         slice_ctl_r  <= 6'd0;
         slice_ai_r   <= 1'b0;
         slice_bi_r   <= 1'b0;
         slice_invb_r <= 1'b0;
         slice_cin_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  funct_r    <= bus.in_funct;
                  a_r        <= bus.in_a;
                  b_r        <= bus.in_b;
                  idx_r      <= {CNT_W{1'b0}};
                  carry_r    <= req_invb_s;
                  in_ready_r <= 1'b0;
                  if (is_legal(bus.in_funct)) begin
                     state_r      <= ST_RUN;
                     slice_ctl_r  <= bus.in_funct;
                     slice_ai_r   <= bus.in_a[0];
                     slice_bi_r   <= bus.in_b[0];
                     slice_invb_r <= req_invb_s;
                     slice_cin_r  <= req_invb_s;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               result_r[idx_r] <= bus.slice_sum;
               carry_r         <= bus.slice_cout;
               if (idx_r == LAST_IDX) begin
                  c_msb_in_r   <= carry_r;
                  c_msb_out_r  <= bus.slice_cout;
                  set_msb_r    <= bus.slice_set;
                  state_r      <= ST_DONE;
                  slice_ctl_r  <= 6'd0;
                  slice_ai_r   <= 1'b0;
                  slice_bi_r   <= 1'b0;
                  slice_invb_r <= 1'b0;
                  slice_cin_r  <= 1'b0;
               end else begin
                  idx_r       <= next_idx_s;
                  slice_ai_r  <= a_r[next_idx_s];
                  slice_bi_r  <= b_r[next_idx_s];
                  slice_cin_r <= bus.slice_cout;
               end
            end
            ST_DONE: begin
               if (!out_valid_r) begin
                  out_valid_r  <= 1'b1;
                  out_result_r <= done_result_s;
                  out_zero_r   <= (done_result_s == {WIDTH{1'b0}});
                  out_ovf_r    <= done_ovf_s;
                  out_err_r    <= !is_legal(funct_r);
               end else if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_result = out_result_r;
   assign bus.out_zero   = out_zero_r;
   assign bus.out_ovf    = out_ovf_r;
   assign bus.out_err    = out_err_r;
   assign bus.slice_ctl  = slice_ctl_r;
   assign bus.slice_ai   = slice_ai_r;
   assign bus.slice_bi   = slice_bi_r;
   assign bus.slice_invb = slice_invb_r;
   assign bus.slice_cin  = slice_cin_r;

endmodule

// File: tb/tb_alu_bit_serial_sequencer.sv
// Bench for the bit-serial ALU sequencer: models the one-bit slice, drives directed and
// random operations, and compares against a whole-word arithmetic reference.
module tb_alu_bit_serial_sequencer;

   localparam int W = 32;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   alu_bit_serial_sequencer_if #(.WIDTH(W)) bus ();

   alu_bit_serial_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External one-bit ALU slice
   logic slice_bb_s;
   always_comb begin
      slice_bb_s     = bus.slice_bi ^ bus.slice_invb;
      bus.slice_set  = bus.slice_ai ^ slice_bb_s ^ bus.slice_cin;
      bus.slice_cout = (bus.slice_ai & slice_bb_s) | (bus.slice_ai & bus.slice_cin) |
                       (slice_bb_s & bus.slice_cin);
      case (bus.slice_ctl)
         6'd36:   bus.slice_sum = bus.slice_ai & bus.slice_bi;
         6'd37:   bus.slice_sum = bus.slice_ai | bus.slice_bi;
         6'd42:   bus.slice_sum = 1'b0;
         default: bus.slice_sum = bus.slice_set;
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-word reference using signed arithmetic
   task automatic ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic z, output logic o, output logic e);
      longint sa, sb, sr;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      o = 1'b0;
      e = 1'b0;
      case (f)
         6'd32: begin sr = sa + sb; r = a + b; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
         6'd34: begin sr = sa - sb; r = a - b; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648); end
         6'd36: r = a & b;
         6'd37: r = a | b;
         6'd42: r = (sa < sb) ? 32'd1 : 32'd0;
         default: begin r = 32'd0; e = 1'b1; end
      endcase
      z = (r == 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int bp);
      logic [W-1:0] er;
      logic ez, eo, ee;
      int cnt;
      logic [W-1:0] held;
      ref_op(f, a, b, er, ez, eo, ee);
      @(negedge clk);
      check({tag, ".in_ready_idle"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_funct = f;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk);
      #1;
      if (!ee) check({tag, ".slice_ctl"}, 64'(bus.slice_ctl), 64'(f));
      check({tag, ".in_ready_busy"}, 64'(bus.in_ready), 64'd0);
      cnt = 0;
      while (!bus.out_valid && cnt < 100) begin
         bus.in_funct = 6'($urandom);
         bus.in_a     = $urandom;
         bus.in_b     = $urandom;
         @(posedge clk);
         #1;
         cnt++;
      end
      bus.in_valid = 1'b0;
      check({tag, ".latency"}, 64'(cnt), ee ? 64'd1 : 64'(W + 1));
      check({tag, ".result"}, 64'(bus.out_result), 64'(er));
      check({tag, ".zero"}, 64'(bus.out_zero), 64'(ez));
      check({tag, ".ovf"}, 64'(bus.out_ovf), 64'(eo));
      check({tag, ".err"}, 64'(bus.out_err), 64'(ee));
      held = bus.out_result;
      for (int k = 0; k < bp; k++) begin
         @(posedge clk);
         #1;
         check({tag, ".bp_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, ".bp_result"}, 64'(bus.out_result), 64'(held));
         check({tag, ".bp_in_ready"}, 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".in_ready_back"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      logic [5:0] legal_f [5];
      logic [5:0] f;
      n_assert = 0;
      n_fail   = 0;
      legal_f  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
      bus.in_valid  = 1'b0;
      bus.in_funct  = 6'd0;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst.in_ready", 64'(bus.in_ready), 64'd1);
      check("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst.out_result", 64'(bus.out_result), 64'd0);
      check("rst.flags", 64'({bus.out_zero, bus.out_ovf, bus.out_err}), 64'd0);
      check("rst.slice", 64'({bus.slice_ctl, bus.slice_ai, bus.slice_bi, bus.slice_invb, bus.slice_cin}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("add_5_3",   6'd32, 32'h0000_0005, 32'h0000_0003, 0);
      run_op("sub_ovf",   6'd34, 32'h8000_0000, 32'h0000_0001, 1);
      run_op("sub_zero",  6'd34, 32'h0000_0005, 32'h0000_0005, 0);
      run_op("slt_neg",   6'd42, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      run_op("slt_ovf",   6'd42, 32'h7FFF_FFFF, 32'h8000_0000, 0);
      run_op("and",       6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
      run_op("or",        6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
      run_op("illegal",   6'h2B, 32'h1234_5678, 32'h9ABC_DEF0, 0);
      run_op("backpress", 6'd32, 32'h7FFF_FFFF, 32'h0000_0001, 10);

      // Reset in the middle of RUN at bit index 15
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_funct = 6'd32;
      bus.in_a     = 32'h0000_1234;
      bus.in_b     = 32'h0000_5678;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst.in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst.out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst.out_result", 64'(bus.out_result), 64'd0);
      check("midrst.slice", 64'({bus.slice_ctl, bus.slice_ai, bus.slice_bi, bus.slice_invb, bus.slice_cin}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_add", 6'd32, 32'd1, 32'd1, 0);

      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            f = 6'($urandom);
            if (f == 6'd32 || f == 6'd34 || f == 6'd36 || f == 6'd37 || f == 6'd42) f = 6'd0;
         end else begin
            f = legal_f[$urandom_range(0, 4)];
         end
         run_op("rand", f, $urandom, (i % 4 == 0) ? 32'h8000_0000 : $urandom,
                int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_bit_serial_sequencer.md
Name: alu_bit_serial_sequencer

Overview:
- Initiator side of the one-bit ALU slice interface.
- Accepts a full-width operation (funct code, operands A/B) on a valid/ready handshake.
- Drives one external one-bit slice LSB-first, one bit per clock, with the carry registered between bits.
- Assembles the result, applies the SLT correction, and returns result plus flags on a second valid/ready handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values 2..64.
- CNT_W, 6, bit-index counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  sequencer can accept a request.
- in_funct  in  6  operation code: 32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- slice_ctl  out  6  funct code presented to the slice.
- slice_ai  out  1  A bit at the current index.
- slice_bi  out  1  B bit at the current index.
- slice_invb  out  1  B-invert to the slice.
- slice_cin  out  1  carry into the current bit.
- slice_sum  in  1  slice result bit (combinational from slice inputs).
- slice_cout  in  1  slice carry out.
- slice_set  in  1  slice raw adder bit.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  operation result.
- out_zero  out  1  out_result == 0.
- out_ovf  out  1  signed overflow; ADD/SUB only, else 0.
- out_err  out  1  illegal funct code.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_err=0, idx=0, carry=0, all slice_* outputs=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Handshake when in_valid & in_ready: latch funct/a/b, set idx=0.
  - invb = 1 for funct 34 or 42, else 0; carry = invb.
  - Legal funct: go to RUN.
  - Illegal funct: go directly to DONE with out_result=0, out_err=1, out_zero=1, out_ovf=0.
- RUN:
  - in_ready=0.
  - slice_ctl=funct, slice_ai=a[idx], slice_bi=b[idx], slice_invb=invb, slice_cin=carry.
  - Each rising edge: result[idx] <= slice_sum; carry <= slice_cout; idx++.
  - At idx=WIDTH-1, also capture c_msb_in=carry, c_msb_out=slice_cout, set_msb=slice_set.
  - Then go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE entry computes:
  - ovf = c_msb_in ^ c_msb_out.
  - SLT: out_result = {0..., set_msb ^ ovf}, out_ovf=0.
  - ADD/SUB: out_ovf = ovf.
  - AND/OR: out_ovf = 0.
  - out_zero reflects the final out_result.
- DONE:
  - out_valid=1; outputs held stable until out_ready.
  - On out_valid & out_ready: out_valid<=0, go to IDLE; in_ready=1 from the next cycle. No same-cycle re-accept.
- Latency: legal op, handshake at edge N gives out_valid=1 after edge N+WIDTH+1 (34 edges for WIDTH=32). Illegal op gives out_valid=1 after edge N+1.
- Outside RUN, slice_* outputs are 0.
- in_valid while busy: ignored, with no latching.
- Request operands may change after the handshake with no effect.
- Arithmetic is modulo 2**WIDTH. AND/OR ignore carry, but the carry register still updates.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no out_valid is produced.

Test Plan:
- ADD a=0x00000005, b=0x00000003 -> after 34 cycles out_result=0x00000008, zero=0, ovf=0, err=0.
- SUB a=0x80000000, b=0x00000001 -> out_result=0x7FFFFFFF, ovf=1. SUB a=5, b=5 -> out_result=0, zero=1.
- SLT a=0xFFFFFFFF (-1), b=0x00000001 -> out_result=1. SLT a=0x7FFFFFFF, b=0x80000000 -> out_result=0, with the overflow correction exercised.
- AND a=0xF0F0F0F0, b=0xFF00FF00 -> 0xF000F000. OR same operands -> 0xFFF0FFF0. ovf=0 for both.
- Illegal funct=0x2B -> out_valid 2 cycles after the handshake, out_err=1, out_result=0, out_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles -> result stable and in_ready=0 throughout. Separately, assert rst_n=0 at RUN idx=15 -> all outputs at reset values; the next ADD 1+1 returns 2.
